// File: rtl/debug_result_sender_if.sv
// debug_result_sender_if
//   Groups the request side (start/result/size -> busy/done) and the UART
//   byte handshake (tx_data/tx_start -> tx_done) of debug_result_sender.
//   slave  : the sender itself
//   master : whoever issues requests and plays the UART transmitter
interface debug_result_sender_if;
  logic        start;
  logic [31:0] result;
  logic [1:0]  size;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic        busy;
  logic        done;

  modport slave (
    input  start, result, size, tx_done,
    output tx_data, tx_start, busy, done
  );

  modport master (
    output start, result, size, tx_done,
    input  tx_data, tx_start, busy, done
  );
endinterface

// File: rtl/debug_result_sender.sv
// debug_result_sender
//   Captures a 32-bit debug word on start and streams size+1 bytes of it to a
//   byte-wide UART transmitter, one tx_start/tx_done handshake per byte.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     bus    debug_result_sender_if.slave
//            start/result/size in, busy/done out,
//            tx_data/tx_start out, tx_done in
//   Parameter:
//     LSB_FIRST  1: result[7:0] first; 0: top byte of the sent field first
//   Build option:
//     DEBUG_TX_CHECKSUM_EN  append one byte = XOR of all data bytes sent
module debug_result_sender #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic reset,
  debug_result_sender_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, FINISH} state_e;

  state_e      state_q, state_d;
  logic [31:0] shadow_q, shadow_d;
  logic [2:0]  cnt_q, cnt_d;      // bytes still to be completed
  logic [1:0]  ptr_q, ptr_d;      // byte index of shadow currently on tx_data
  logic [7:0]  tx_data_q, tx_data_d;
`ifdef DEBUG_TX_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;    // XOR of data bytes loaded so far
`endif

  logic [1:0]  first_ptr;
  logic [1:0]  next_ptr;
  logic [7:0]  next_byte;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    tx_data_d = tx_data_q;
`ifdef DEBUG_TX_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    // MSB-first walks down from the top byte of the requested field
    first_ptr = LSB_FIRST ? 2'd0 : bus.size;
    next_ptr  = LSB_FIRST ? ptr_q + 2'd1 : ptr_q - 2'd1;
    next_byte = byte_sel(shadow_q, next_ptr);

    case (state_q)
      IDLE, FINISH: begin
        state_d = IDLE;
        if (bus.start) begin
          state_d   = SEND;
          shadow_d  = bus.result;
          ptr_d     = first_ptr;
          // first byte is taken straight from result so it is valid with tx_start
          tx_data_d = byte_sel(bus.result, first_ptr);
`ifdef DEBUG_TX_CHECKSUM_EN
          cnt_d     = {1'b0, bus.size} + 3'd2;
          csum_d    = byte_sel(bus.result, first_ptr);
`else
          cnt_d     = {1'b0, bus.size} + 3'd1;
`endif
        end
      end
      SEND: state_d = WAIT;  // tx_done here is deliberately ignored
      WAIT: begin
        if (bus.tx_done) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_d == 3'd0) begin
            state_d = FINISH;
          end else begin
            state_d = SEND;
            ptr_d   = next_ptr;
`ifdef DEBUG_TX_CHECKSUM_EN
            // one byte left means the checksum slot
            if (cnt_d == 3'd1) begin
              tx_data_d = csum_q;
            end else begin
              tx_data_d = next_byte;
              csum_d    = csum_q ^ next_byte;
            end
`else
            tx_data_d = next_byte;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      tx_data_q <= '0;
`ifdef DEBUG_TX_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      tx_data_q <= tx_data_d;
`ifdef DEBUG_TX_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  // Decoded straight from the state flop so reset clears them at once
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = (state_q == SEND);
  assign bus.busy     = (state_q == SEND) || (state_q == WAIT);
  assign bus.done     = (state_q == FINISH);

endmodule

// File: tb/tb_debug_result_sender.sv
module tb_debug_result_sender;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] result;
  logic [1:0]  size;
  logic        tx_done;

  always #5 clk = ~clk;

  debug_result_sender_if if_l();
  debug_result_sender_if if_m();

  assign if_l.start = start;   assign if_m.start = start;
  assign if_l.result = result; assign if_m.result = result;
  assign if_l.size = size;     assign if_m.size = size;
  assign if_l.tx_done = tx_done; assign if_m.tx_done = tx_done;

  debug_result_sender #(.LSB_FIRST(1'b1)) dut_l (.clk(clk), .reset(reset), .bus(if_l.slave));
  debug_result_sender #(.LSB_FIRST(1'b0)) dut_m (.clk(clk), .reset(reset), .bus(if_m.slave));

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_l[$], exp_m[$], obs_l[$], obs_m[$];
  int first_lat, done_lat, n_start;
  bit unstable, busy_bad, gap_bad, desync, timeout;

  // Reference: byte k of the word is (r >> 8k) & FF; order is a list reversal
  task automatic build_exp(input logic [31:0] r, input logic [1:0] s);
    int n;
    logic [7:0] x;
    n = int'(s) + 1;
    x = 8'h00;
    exp_l.delete(); exp_m.delete();
    for (int k = 0; k < n; k++) begin
      exp_l.push_back(8'((r >> (8 * k)) & 32'hFF));
      x = x ^ 8'((r >> (8 * k)) & 32'hFF);
    end
    for (int k = n - 1; k >= 0; k--) exp_m.push_back(8'((r >> (8 * k)) & 32'hFF));
`ifdef DEBUG_TX_CHECKSUM_EN
    exp_l.push_back(x);
    exp_m.push_back(x);
`endif
  endtask

  function automatic bit q_eq(input logic [7:0] a[$], input logic [7:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string q2s(input logic [7:0] q[$]);
    string s;
    s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  // Caller must be at a negedge. Drives start now, then acts as the UART:
  // tx_done goes high dly cycles after each tx_start. Returns on done, on the
  // stop_after-th tx_start (if non-zero), or on timeout.
  task automatic xfer(input logic [31:0] r, input logic [1:0] s, input int dly,
                      input bit poke, input bit glitch, input int stop_after);
    int cyc, cnt, last_td;
    bit waiting;
    logic [7:0] cur_l, cur_m;
    cyc = 0; cnt = 0; last_td = -100; waiting = 0; cur_l = '0; cur_m = '0;
    obs_l.delete(); obs_m.delete();
    first_lat = -1; done_lat = -1; n_start = 0;
    unstable = 0; busy_bad = 0; gap_bad = 0; desync = 0; timeout = 0;
    start = 1'b1; result = r; size = s; tx_done = 1'b0;
    while (1) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; result = $urandom; size = 2'($urandom); tx_done = 1'b0;
      if (if_l.tx_start !== if_m.tx_start || if_l.busy !== if_m.busy || if_l.done !== if_m.done)
        desync = 1;
      if (if_l.tx_start === 1'b1) begin
        n_start++;
        if (first_lat < 0) first_lat = cyc;
        else if (cyc - last_td != 1) gap_bad = 1;
        obs_l.push_back(if_l.tx_data); obs_m.push_back(if_m.tx_data);
        cur_l = if_l.tx_data; cur_m = if_m.tx_data;
        waiting = 1; cnt = dly;
        if (if_l.busy !== 1'b1) busy_bad = 1;
        if (glitch) tx_done = 1'b1;
        if (stop_after == n_start) break;
      end else if (waiting) begin
        if (if_l.tx_data !== cur_l || if_m.tx_data !== cur_m) unstable = 1;
        if (if_l.busy !== 1'b1) busy_bad = 1;
        cnt--;
        if (cnt == 0) begin tx_done = 1'b1; waiting = 0; last_td = cyc; end
        if (poke) begin start = 1'b1; result = 32'hFFFF_FFFF; size = 2'b11; end
      end
      if (if_l.done === 1'b1) begin
        done_lat = cyc - last_td;
        if (if_l.busy !== 1'b0) busy_bad = 1;
        break;
      end
      if (cyc > 400) begin timeout = 1; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; tx_done = 1'b0; result = '0; size = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({if_l.tx_data, if_l.tx_start, if_l.busy, if_l.done} !== 11'd0) begin
      errors++; $display("FAIL reset_l: got %h want 0", {if_l.tx_data, if_l.tx_start, if_l.busy, if_l.done});
    end
    checks++;
    if ({if_m.tx_data, if_m.tx_start, if_m.busy, if_m.done} !== 11'd0) begin
      errors++; $display("FAIL reset_m: got %h want 0", {if_m.tx_data, if_m.tx_start, if_m.busy, if_m.done});
    end
    reset = 1'b0;
    begin
      bit act;
      act = 0;
      repeat (6) begin
        @(negedge clk);
        if (if_l.tx_start !== 1'b0 || if_m.tx_start !== 1'b0 || if_l.busy !== 1'b0) act = 1;
      end
      checks++;
      if (act) begin errors++; $display("FAIL post_reset_idle: activity=%0d want 0", act); end
    end
  endtask

  task automatic test_transfers;
    logic [31:0] r;
    logic [1:0]  s;
    int d;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: begin r = 32'h1234_5678; s = 2'b11; d = 5; end
        1: begin r = 32'h00AA_BBCC; s = 2'b10; d = 3; end
        2: begin r = 32'h0000_0055; s = 2'b00; d = 2; end
        default: begin r = $urandom; s = 2'($urandom); d = $urandom_range(1, 6); end
      endcase
      build_exp(r, s);
      @(negedge clk);
      xfer(r, s, d, 1'b0, 1'b0, 0);
      checks++;
      if (!q_eq(obs_l, exp_l)) begin
        errors++; $display("FAIL bytes_lsb[%0d]: got %s want %s", i, q2s(obs_l), q2s(exp_l));
      end
      checks++;
      if (!q_eq(obs_m, exp_m)) begin
        errors++; $display("FAIL bytes_msb[%0d]: got %s want %s", i, q2s(obs_m), q2s(exp_m));
      end
      checks++;
      if (first_lat !== 1) begin errors++; $display("FAIL start_latency[%0d]: got %0d want 1", i, first_lat); end
      checks++;
      if (done_lat !== 1) begin errors++; $display("FAIL done_latency[%0d]: got %0d want 1", i, done_lat); end
      checks++;
      if (n_start !== exp_l.size()) begin
        errors++; $display("FAIL tx_start_count[%0d]: got %0d want %0d", i, n_start, exp_l.size());
      end
      checks++;
      if ({gap_bad, unstable, busy_bad, desync, timeout} !== 5'b0) begin
        errors++; $display("FAIL protocol[%0d]: gap/unstable/busy/desync/timeout=%b want 00000", i,
                           {gap_bad, unstable, busy_bad, desync, timeout});
      end
    end
  endtask

  task automatic test_ignore;
    logic [7:0] sl, sm;
    logic [31:0] r;
    bit moved;
    // spurious tx_done while idle
    repeat (2) @(negedge clk);
    sl = if_l.tx_data; sm = if_m.tx_data; moved = 0;
    tx_done = 1'b1;
    repeat (4) begin
      @(negedge clk);
      tx_done = 1'b0;
      if (if_l.tx_data !== sl || if_m.tx_data !== sm || if_l.tx_start !== 1'b0 ||
          if_l.busy !== 1'b0 || if_l.done !== 1'b0) moved = 1;
    end
    checks++;
    if (moved) begin errors++; $display("FAIL idle_tx_done: output changed=%0d want 0", moved); end
    // start held during WAIT and tx_done coinciding with tx_start are both ignored
    r = $urandom;
    build_exp(r, 2'b11);
    @(negedge clk);
    xfer(r, 2'b11, 4, 1'b1, 1'b1, 0);
    checks++;
    if (!q_eq(obs_l, exp_l)) begin errors++; $display("FAIL ignore_lsb: got %s want %s", q2s(obs_l), q2s(exp_l)); end
    checks++;
    if (!q_eq(obs_m, exp_m)) begin errors++; $display("FAIL ignore_msb: got %s want %s", q2s(obs_m), q2s(exp_m)); end
    checks++;
    if (done_lat !== 1 || timeout) begin
      errors++; $display("FAIL ignore_done: got lat %0d timeout %0d want 1/0", done_lat, timeout);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r1, r2;
    logic [1:0] s1, s2;
    r1 = $urandom; s1 = 2'($urandom); r2 = $urandom; s2 = 2'($urandom);
    build_exp(r1, s1);
    @(negedge clk);
    xfer(r1, s1, 2, 1'b0, 1'b0, 0);
    checks++;
    if (!q_eq(obs_l, exp_l) || done_lat !== 1) begin
      errors++; $display("FAIL b2b_first: got %s lat %0d want %s lat 1", q2s(obs_l), done_lat, q2s(exp_l));
    end
    // restart while done is high (FINISH)
    build_exp(r2, s2);
    xfer(r2, s2, 3, 1'b0, 1'b0, 0);
    checks++;
    if (!q_eq(obs_m, exp_m) || first_lat !== 1) begin
      errors++; $display("FAIL b2b_second: got %s lat %0d want %s lat 1", q2s(obs_m), first_lat, q2s(exp_m));
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    bit act;
    r = $urandom;
    @(negedge clk);
    xfer(r, 2'b11, 4, 1'b0, 1'b0, 2);
    @(negedge clk);  // now waiting on byte 2
    checks++;
    if (if_l.busy !== 1'b1 || timeout) begin errors++; $display("FAIL mid_busy: got %b want 1", if_l.busy); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({if_l.tx_data, if_l.tx_start, if_l.busy, if_l.done, if_m.tx_data, if_m.tx_start, if_m.busy, if_m.done} !== 22'd0) begin
      errors++; $display("FAIL mid_reset_outputs: got %h/%h want 0/0",
                         {if_l.tx_data, if_l.tx_start, if_l.busy, if_l.done},
                         {if_m.tx_data, if_m.tx_start, if_m.busy, if_m.done});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    act = 0;
    repeat (8) begin
      @(negedge clk);
      if (if_l.tx_start !== 1'b0 || if_m.tx_start !== 1'b0 || if_l.done !== 1'b0) act = 1;
    end
    checks++;
    if (act) begin errors++; $display("FAIL mid_reset_quiet: activity=%0d want 0", act); end
    build_exp(32'h0000_00A5, 2'b00);
    xfer(32'h0000_00A5, 2'b00, 3, 1'b0, 1'b0, 0);
    checks++;
    if (!q_eq(obs_l, exp_l) || !q_eq(obs_m, exp_m) || obs_l[0] !== 8'hA5 || done_lat !== 1) begin
      errors++; $display("FAIL after_reset_xfer: got %s / %s lat %0d want %s lat 1",
                         q2s(obs_l), q2s(obs_m), done_lat, q2s(exp_l));
    end
  endtask

`ifdef DEBUG_TX_CHECKSUM_EN
  task automatic test_checksum;
    build_exp(32'h0000_F00F, 2'b01);
    @(negedge clk);
    xfer(32'h0000_F00F, 2'b01, 2, 1'b0, 1'b0, 0);
    checks++;
    if (obs_l.size() != 3 || obs_l[0] !== 8'h0F || obs_l[1] !== 8'hF0 || obs_l[2] !== 8'hFF) begin
      errors++; $display("FAIL checksum_bytes: got %s want 0f f0 ff", q2s(obs_l));
    end
    checks++;
    if (n_start !== 3 || done_lat !== 1) begin
      errors++; $display("FAIL checksum_done: got starts %0d lat %0d want 3/1", n_start, done_lat);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_transfers;
    test_ignore;
    test_back_to_back;
    test_reset_mid;
`ifdef DEBUG_TX_CHECKSUM_EN
    test_checksum;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
